// File: rtl/pair_packer_pkg.sv
// Shared constants, FSM state type and pair placement helper for pair_packer.
package pair_packer_pkg;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_PEND = 1'b1
    } state_t;

    function automatic int pair_lo_index(input int k, input int word_w, input int order);
        return (order == ORDER_MSB_FIRST) ? (word_w - 2 - 2 * k) : (2 * k);
    endfunction

endpackage

// File: rtl/pair_slot_reg.sv
// Single-entry output holding register for pair_packer words with valid/ready.
// PAIR_PACKER_PARITY_EN adds a registered parity bit alongside the word.
module pair_slot_reg #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic [CNT_W-1:0]  out_cnt,
`ifdef PAIR_PACKER_PARITY_EN
    output logic              out_par,
`endif
    output logic              slot_free
);

    assign slot_free = !out_valid || out_ready;

    // Word and count only change on load, so they hold steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_cnt   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_word  <= load_word;
            out_cnt   <= load_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PAIR_PACKER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (load) begin
            out_par <= ^load_word;
        end
    end
`endif

endmodule

// File: rtl/pair_packer.sv
// Packs 2-bit pairs into WORD_W-bit words; FLUSH emits a partial word.
// PAIR_PACKER_PARITY_EN adds out_par = XOR of out_word.
//   state      | meaning
//   FILL       | accepting pairs into acc
//   FLUSH_PEND | partial word waiting for the output slot, input stalled
module pair_packer
    import pair_packer_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int ORDER  = ORDER_LSB_FIRST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_pair,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_word,
`ifdef PAIR_PACKER_PARITY_EN
    output logic                          out_par,
`endif
    output logic [$clog2(WORD_W/2):0]     out_cnt
);

    localparam int NP  = WORD_W / 2;
    localparam int CW  = $clog2(NP);
    localparam int OCW = CW + 1;
    localparam logic [CW-1:0] LAST = CW'(NP - 1);

    state_t            state;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [CW-1:0]     cnt;
    logic [OCW-1:0]    eff_cnt;
    logic              accept;
    logic              full;
    logic              slot_free;
    logic              load;

    assign in_ready = (state == FILL) && !(cnt == LAST && !slot_free);
    assign accept   = in_valid && in_ready;
    assign full     = accept && (cnt == LAST);
    assign eff_cnt  = {1'b0, cnt} + OCW'(accept);

    always_comb begin
        acc_next = acc;
        for (int k = 0; k < NP; k++) begin
            if (accept && cnt == CW'(k)) begin
                acc_next[pair_lo_index(k, WORD_W, ORDER) +: 2] = in_pair;
            end
        end
    end

    // In FLUSH_PEND nothing is accepted, so acc_next/eff_cnt are just acc/cnt.
    always_comb begin
        load = 1'b0;
        case (state)
            FILL:       load = full || (flush && eff_cnt != '0 && slot_free);
            FLUSH_PEND: load = slot_free;
            default:    load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (load) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (flush && eff_cnt != '0) begin
                        acc   <= acc_next;
                        cnt   <= eff_cnt[CW-1:0];
                        state <= FLUSH_PEND;
                    end else if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                FLUSH_PEND: begin
                    if (load) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    pair_slot_reg #(
        .WORD_W(WORD_W),
        .CNT_W (OCW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word (acc_next),
        .load_cnt  (eff_cnt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_cnt   (out_cnt),
`ifdef PAIR_PACKER_PARITY_EN
        .out_par   (out_par),
`endif
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_pair_packer.sv
// Directed bench: two pair_packer instances (ORDER=0 and ORDER=1) share stimulus.
module tb_pair_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_pair;
    logic       flush;
    logic       out_ready;

    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [7:0] out_word0, out_word1;
    logic [2:0] out_cnt0, out_cnt1;
`ifdef PAIR_PACKER_PARITY_EN
    logic       out_par0, out_par1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pair_packer #(.WORD_W(8), .ORDER(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_pair   (in_pair),
        .flush     (flush),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_word  (out_word0),
`ifdef PAIR_PACKER_PARITY_EN
        .out_par   (out_par0),
`endif
        .out_cnt   (out_cnt0)
    );

    pair_packer #(.WORD_W(8), .ORDER(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_pair   (in_pair),
        .flush     (flush),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_word  (out_word1),
`ifdef PAIR_PACKER_PARITY_EN
        .out_par   (out_par1),
`endif
        .out_cnt   (out_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] p);
        in_valid = 1'b1;
        in_pair  = p;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [2:0] c);
        chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
        chk({tag, "_valid1"}, 32'(out_valid1), 32'd1);
        chk({tag, "_word0"}, 32'(out_word0), 32'(w0));
        chk({tag, "_word1"}, 32'(out_word1), 32'(w1));
        chk({tag, "_cnt"}, 32'(out_cnt0), 32'(c));
        chk({tag, "_cnt1"}, 32'(out_cnt1), 32'(c));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pair   = 2'b00;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_word", 32'(out_word0), 32'd0);
        chk("rst_cnt", 32'(out_cnt0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
`ifdef PAIR_PACKER_PARITY_EN
        chk("rst_par", 32'(out_par0), 32'd0);
`endif

        // Back-to-back full word
        in_valid = 1'b1;
        in_pair = 2'b01; cyc();
        in_pair = 2'b10; cyc();
        in_pair = 2'b11; cyc();
        in_pair = 2'b00; cyc();
        in_valid = 1'b0;
        chk_word("full", 8'h39, 8'h6C, 3'd4);
`ifdef PAIR_PACKER_PARITY_EN
        chk("par_39", 32'(out_par0), 32'd0);
`endif
        cyc();
        chk("full_drain", 32'(out_valid0), 32'd0);

        // Backpressure: hold 0x39, then fill the next word behind it
        out_ready = 1'b0;
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        chk_word("bp_held", 8'h39, 8'h6C, 3'd4);
        in_valid = 1'b1;
        in_pair = 2'b11; cyc();
        in_pair = 2'b11; cyc();
        in_pair = 2'b00; cyc();
        in_pair = 2'b10;
        #1;
        chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
        chk("bp_in_ready_low1", 32'(in_ready1), 32'd0);
        cyc();
        chk_word("bp_stable", 8'h39, 8'h6C, 3'd4);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready0), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk_word("bp_second", 8'h8F, 8'hF2, 3'd4);
        cyc();
        chk("bp_no_dup", 32'(out_valid0), 32'd0);

        // Flush of a two-pair partial word
        send(2'b11); send(2'b01);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk_word("flush2", 8'h07, 8'hD0, 3'd2);
`ifdef PAIR_PACKER_PARITY_EN
        chk("par_07", 32'(out_par0), 32'd1);
`endif
        cyc();
        chk("flush2_drain", 32'(out_valid0), 32'd0);

        // Flush with nothing buffered is ignored
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("flush_empty", 32'(out_valid0), 32'd0);
        cyc();
        chk("flush_empty2", 32'(out_valid0), 32'd0);

        // Flush together with the only pair: the pair is included
        in_valid = 1'b1; in_pair = 2'b11; flush = 1'b1;
        cyc();
        in_valid = 1'b0; flush = 1'b0;
        chk_word("flush_acc", 8'h03, 8'hC0, 3'd1);
        cyc();

        // Flush blocked by a held word
        out_ready = 1'b0;
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        send(2'b10);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("pend_in_ready", 32'(in_ready0), 32'd0);
        chk_word("pend_held", 8'h39, 8'h6C, 3'd4);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("pend_in_ready2", 32'(in_ready0), 32'd0);
        out_ready = 1'b1;
        cyc();
        chk_word("pend_partial", 8'h02, 8'h80, 3'd1);
        chk("pend_release", 32'(in_ready0), 32'd1);
        cyc();
        chk("pend_drain", 32'(out_valid0), 32'd0);

        // Flush on the final pair: one full word, no trailing empty word
        in_valid = 1'b1;
        in_pair = 2'b10; cyc();
        in_pair = 2'b01; cyc();
        in_pair = 2'b00; cyc();
        in_pair = 2'b11; flush = 1'b1; cyc();
        in_valid = 1'b0; flush = 1'b0;
        chk_word("flush_full", 8'hC6, 8'h93, 3'd4);
        cyc();
        chk("flush_full_trail", 32'(out_valid0), 32'd0);
        cyc();
        chk("flush_full_trail2", 32'(out_valid0), 32'd0);

        // Reset mid-word discards the partial word
        send(2'b11); send(2'b11); send(2'b11);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_valid", 32'(out_valid0), 32'd0);
        chk("midrst_cnt", 32'(out_cnt0), 32'd0);
        cyc();
        chk("midrst_valid2", 32'(out_valid0), 32'd0);
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        chk_word("midrst_fresh", 8'h39, 8'h6C, 3'd4);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pair_packer.md
Name: pair_packer

Overview:
Downstream consumer of the 2-bit pair bus {IN1, IN2} (bit1 = IN1, bit0 = IN2). It accumulates WORD_W/2 consecutive pairs into one WORD_W-bit word. Bit placement is selectable: first pair in the LSBs or first pair in the MSBs. Words are delivered over a valid/ready handshake, and a flush request emits a partially filled word.

Parameters:
WORD_W, 8, output word width; even, >= 4
ORDER, 0, 0 = first pair in LSBs (pair k -> OUT_WORD[2k+1:2k]); 1 = first pair in MSBs (pair k -> OUT_WORD[WORD_W-1-2k:WORD_W-2-2k])

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
IN_VALID  input  1  IN_PAIR valid
IN_READY  output  1  pair accepted when IN_VALID && IN_READY
IN_PAIR  input  2  {IN1, IN2} pair
FLUSH  input  1  single-cycle pulse: emit partial word
OUT_VALID  output  1  OUT_WORD/OUT_CNT valid
OUT_READY  input  1  consumer accepts when OUT_VALID && OUT_READY
OUT_WORD  output  WORD_W  packed word; unfilled pair slots are zero
OUT_CNT  output  $clog2(WORD_W/2)+1  number of valid pairs in OUT_WORD (1..WORD_W/2)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Internal state: assembly register ACC, fill count CNT (0..WORD_W/2-1), single-entry output slot, and FLUSH_PEND flag.
- Reset values: OUT_VALID=0, OUT_WORD=0, OUT_CNT=0, ACC=0, CNT=0, FLUSH_PEND=0. IN_READY=1 from the first cycle after reset.
- Reset mid-word discards the partial word and any held output word. Nothing is emitted.
- Slot free: slot_free = !OUT_VALID || OUT_READY. The output slot can be refilled in the same cycle it drains.
- Accept: the pair is written into position CNT of ACC per ORDER, and CNT increments.
- Full: when the accepted pair is pair WORD_W/2-1, on the same edge ACC (with the new pair) moves to the slot. OUT_CNT=WORD_W/2, CNT returns to 0, ACC clears.
- Latency: OUT_VALID rises the cycle after the last pair is accepted. Sustained throughput is 1 pair/cycle with OUT_READY=1.
- IN_READY = !FLUSH_PEND && !(CNT==WORD_W/2-1 && !slot_free). A full word is never accepted without a slot for it.
- The held word and OUT_CNT are stable while OUT_VALID && !OUT_READY.
- State machine FILL / FLUSH_PEND:
  - FILL: on FLUSH, if effective count (CNT plus the pair accepted this cycle) is 0, the flush is ignored.
  - FILL: if the effective count is WORD_W/2, a normal full word is emitted; no extra empty word follows.
  - FILL: otherwise, if slot_free, the partial word moves to the slot with OUT_CNT = effective count, and CNT and ACC clear.
  - FILL: otherwise, go to FLUSH_PEND.
  - FLUSH_PEND: IN_READY=0. Move to the slot on the first cycle slot_free holds, then return to FILL.
  - FLUSH while already in FLUSH_PEND is absorbed.
- Partial words, ORDER=1: filled pairs occupy the MSBs and the low bits are zero. ORDER=0: filled pairs occupy the LSBs and the high bits are zero.

Optional Feature:
PAIR_PACKER_PARITY_EN:
- Defined: adds output OUT_PAR (1 bit) = XOR reduction of OUT_WORD. It is registered together with the word, valid with OUT_VALID, and 0 at reset.
- Undefined: port OUT_PAR and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pair_packer_pkg: constants ORDER_LSB_FIRST=0 and ORDER_MSB_FIRST=1; state enum {FILL, FLUSH_PEND}; function pair_lo_index(k, WORD_W, ORDER) returning the low bit index of pair k.
- Sub-module pair_slot_reg: single-entry output holding register (word, count, optional parity) with valid/ready and slot_free output.
- Packing and FSM logic stay in pair_packer.

Test Plan:
- ORDER=0, WORD_W=8, OUT_READY=1; pairs 01,10,11,00 back-to-back -> one cycle after 4th accept: OUT_VALID=1, OUT_WORD=8'h39, OUT_CNT=4. Same stimulus with ORDER=1 -> OUT_WORD=8'h6C.
- Backpressure: OUT_READY=0 with word 8'h39 held; send 4 more pairs -> 3 accepted, IN_READY=0 on the 4th. Raise OUT_READY -> 8'h39 drains, 4th pair accepted the same cycle, second word follows the next cycle, no loss or duplication.
- Flush: pairs 11,01 then FLUSH -> ORDER=0: OUT_WORD=8'h07, OUT_CNT=2. ORDER=1: OUT_WORD=8'hD0, OUT_CNT=2. FLUSH with CNT=0 and no input -> no OUT_VALID.
- Flush blocked: slot held (OUT_READY=0), 1 pair in ACC, FLUSH -> IN_READY=0 (FLUSH_PEND). Release OUT_READY -> partial word with OUT_CNT=1 emitted after the held word.
- Simultaneous FLUSH with the 4th pair -> exactly one word, OUT_CNT=4, no trailing empty word.
- Reset mid-word: 3 pairs accepted, RST for 1 cycle -> OUT_VALID=0, next 4 pairs form a fresh word. With PAIR_PACKER_PARITY_EN, check OUT_PAR=0 for 8'h39 and OUT_PAR=1 for 8'h07.
